// File: rtl/geig_packet_tx_if.sv
// geig_packet_tx_if -- bundle of the geiger-packet input strobe, the byte
// downlink handshake and the status outputs of geig_packet_tx.
//
// Signals:
//   G_DATA_STACK  [47:0] packet {counts[47:32], timestamp[31:8], ID[7:0]}
//   G_STACK_VALID        one-cycle strobe qualifying G_DATA_STACK
//   TX_READY             downlink can take a byte this edge
//   TX_BYTE       [7:0]  byte currently offered to the downlink
//   TX_VALID             TX_BYTE is valid
//   TX_LAST              TX_BYTE is the final byte of the packet
//   FIFO_COUNT    [2:0]  packets waiting in the queue (0..4)
//   OVERFLOW             sticky: a packet was dropped
//
// Handshake: a byte transfers on a rising edge where TX_VALID=1 and
// TX_READY=1. While TX_VALID=1 and TX_READY=0 the sender holds TX_BYTE,
// TX_VALID and TX_LAST unchanged. TX_READY is ignored while TX_VALID=0.
//
// Modports: master = packet source / downlink side, slave = geig_packet_tx.
interface geig_packet_tx_if;
  logic [47:0] G_DATA_STACK;
  logic        G_STACK_VALID;
  logic        TX_READY;
  logic [7:0]  TX_BYTE;
  logic        TX_VALID;
  logic        TX_LAST;
  logic [2:0]  FIFO_COUNT;
  logic        OVERFLOW;

  modport master (
    output G_DATA_STACK, G_STACK_VALID, TX_READY,
    input  TX_BYTE, TX_VALID, TX_LAST, FIFO_COUNT, OVERFLOW
  );

  modport slave (
    input  G_DATA_STACK, G_STACK_VALID, TX_READY,
    output TX_BYTE, TX_VALID, TX_LAST, FIFO_COUNT, OVERFLOW
  );
endinterface

// File: rtl/geig_packet_tx.sv
// geig_packet_tx -- queues 48-bit geiger packets in a 4-deep FIFO and
// serialises each one, MSB byte first, onto a valid/ready byte downlink.
//
// Ports:
//   CLK_10HZ     system clock, rising edge
//   RESET        asynchronous, active-low reset
//   bus          geig_packet_tx_if.slave (packet input, byte downlink, status)
//   o_dbg_state  1 while the serialiser is in SEND, 0 in IDLE
//
// Build option: define GEIG_CHECKSUM_EN to append a 7th byte holding the
// XOR of the six data bytes; TX_LAST then marks that byte instead of [7:0].
module geig_packet_tx (
  input  logic              CLK_10HZ,
  input  logic              RESET,
  geig_packet_tx_if.slave   bus,
  output logic              o_dbg_state
);

`ifdef GEIG_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd6;
`else
  localparam logic [2:0] LAST_IDX = 3'd5;
`endif

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  logic [47:0] r_fifo [4];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_count;
  logic        r_overflow;

  state_t      r_state;
  logic [47:0] r_hold;
  logic [2:0]  r_idx;
  logic [7:0]  r_tx_byte;
  logic        r_tx_valid;
  logic        r_tx_last;

  logic        w_pop;
  logic        w_push;
  logic        w_drop;

  // Byte k of a packet, MSB first; index 6 is the optional checksum.
  function automatic logic [7:0] byte_at(input logic [47:0] pkt, input logic [2:0] idx);
    logic [7:0] v;
    case (idx)
      3'd0:    v = pkt[47:40];
      3'd1:    v = pkt[39:32];
      3'd2:    v = pkt[31:24];
      3'd3:    v = pkt[23:16];
      3'd4:    v = pkt[15:8];
      3'd5:    v = pkt[7:0];
`ifdef GEIG_CHECKSUM_EN
      default: v = pkt[47:40] ^ pkt[39:32] ^ pkt[31:24] ^ pkt[23:16] ^ pkt[15:8] ^ pkt[7:0];
`else
      default: v = 8'h00;
`endif
    endcase
    return v;
  endfunction

  // The head is popped only from IDLE; a push to a full FIFO still fits when
  // that pop frees a slot on the same edge.
  assign w_pop  = (r_state == IDLE) && (r_count != 3'd0);
  assign w_push = bus.G_STACK_VALID && ((r_count != 3'd4) || w_pop);
  assign w_drop = bus.G_STACK_VALID && !w_push;

  always_ff @(posedge CLK_10HZ or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < 4; i++) r_fifo[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= bus.G_DATA_STACK;
        r_wr_ptr         <= r_wr_ptr + 2'd1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge CLK_10HZ or negedge RESET) begin
    if (!RESET) begin
      r_state    <= IDLE;
      r_hold     <= '0;
      r_idx      <= '0;
      r_tx_byte  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_tx_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_hold     <= r_fifo[r_rd_ptr];
            r_idx      <= 3'd0;
            r_tx_byte  <= byte_at(r_fifo[r_rd_ptr], 3'd0);
            r_tx_valid <= 1'b1;
            r_tx_last  <= 1'b0;
            r_state    <= SEND;
          end
        end
        SEND: begin
          if (bus.TX_READY) begin
            if (r_idx == LAST_IDX) begin
              // Dropping to IDLE guarantees one invalid cycle between packets.
              r_tx_valid <= 1'b0;
              r_tx_last  <= 1'b0;
              r_state    <= IDLE;
            end else begin
              r_idx      <= r_idx + 3'd1;
              r_tx_byte  <= byte_at(r_hold, r_idx + 3'd1);
              r_tx_last  <= ((r_idx + 3'd1) == LAST_IDX);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.TX_BYTE    = r_tx_byte;
  assign bus.TX_VALID   = r_tx_valid;
  assign bus.TX_LAST    = r_tx_last;
  assign bus.FIFO_COUNT = r_count;
  assign bus.OVERFLOW   = r_overflow;
  assign o_dbg_state    = (r_state == SEND);

endmodule

// File: tb/tb_geig_packet_tx.sv
module tb_geig_packet_tx;

`ifdef GEIG_CHECKSUM_EN
  localparam int NUM_BYTES = 7;
`else
  localparam int NUM_BYTES = 6;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  geig_packet_tx_if bus();
  logic dbg_state;

  geig_packet_tx dut (
    .CLK_10HZ    (clk),
    .RESET       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- reference model / scoreboard ----------------
  int n_cmp = 0;
  int n_mis = 0;

  logic [47:0] m_q[$];      // packets waiting in the queue
  logic [7:0]  m_cur[$];    // bytes of the packet being sent, head = offered
  bit          m_send = 0;
  bit          m_ovf  = 0;
  logic [7:0]  exp_q[$];    // every byte the downlink should receive, in order
  logic [7:0]  got_q[$];    // bytes actually transferred (per test)

  task automatic chk(input string tag, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pkt_byte(input logic [47:0] p, input int k);
    logic [7:0] x;
    if (k < 6) return p[47 - 8*k -: 8];
    x = 8'h00;
    for (int j = 0; j < 6; j++) x ^= p[47 - 8*j -: 8];
    return x;
  endfunction

  task automatic check_state();
    chk("tx_valid", bus.TX_VALID, m_send);
    chk("dbg_state", dbg_state, m_send);
    if (m_send) begin
      chk("tx_byte", bus.TX_BYTE, m_cur[0]);
      chk("tx_last", bus.TX_LAST, m_cur.size() == 1);
    end else begin
      chk("tx_last_idle", bus.TX_LAST, 1'b0);
    end
    chk("fifo_count", bus.FIFO_COUNT, m_q.size());
    chk("overflow", bus.OVERFLOW, m_ovf);
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge; returns just after the next one.
  task automatic tick(input bit v, input logic [47:0] d, input bit rdy);
    bit pop;
    bit acc;
    logic [47:0] p;
    bus.G_STACK_VALID = v;
    bus.G_DATA_STACK  = d;
    bus.TX_READY      = rdy;
    #1;
    if (bus.TX_VALID && rdy) begin
      got_q.push_back(bus.TX_BYTE);
      if (exp_q.size() == 0) chk("sb_extra_byte", bus.TX_VALID, 1'b0);
      else chk("sb_byte", bus.TX_BYTE, exp_q.pop_front());
    end
    @(posedge clk);
    pop = !m_send && (m_q.size() > 0);
    acc = v && ((m_q.size() < 4) || pop);
    if (v && !acc) m_ovf = 1;
    if (m_send) begin
      if (rdy) begin
        void'(m_cur.pop_front());
        if (m_cur.size() == 0) m_send = 0;
      end
    end else if (pop) begin
      p = m_q.pop_front();
      m_cur.delete();
      for (int k = 0; k < NUM_BYTES; k++) m_cur.push_back(pkt_byte(p, k));
      m_send = 1;
    end
    if (acc) begin
      m_q.push_back(d);
      for (int k = 0; k < NUM_BYTES; k++) exp_q.push_back(pkt_byte(d, k));
    end
    #1;
    check_state();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.G_STACK_VALID = 1'b0;
    bus.G_DATA_STACK  = '0;
    bus.TX_READY      = 1'b0;
    #1;
    m_q.delete(); m_cur.delete(); exp_q.delete();
    m_send = 0; m_ovf = 0;
    chk("rst_tx_valid", bus.TX_VALID, 1'b0);
    chk("rst_tx_last", bus.TX_LAST, 1'b0);
    chk("rst_tx_byte", bus.TX_BYTE, 8'h00);
    chk("rst_fifo_count", bus.FIFO_COUNT, 3'd0);
    chk("rst_overflow", bus.OVERFLOW, 1'b0);
    chk("rst_dbg_state", dbg_state, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((m_send || m_q.size() != 0) && n < max_cycles) begin
      tick(1'b0, '0, 1'b1);
      n++;
    end
    chk("drain_timeout", n < max_cycles, 1'b1);
    tick(1'b0, '0, 1'b1);
  endtask

  function automatic logic [47:0] rnd_pkt();
    return {$urandom_range(0, 65535), $urandom()};
  endfunction

  // ---------------- stimulus ----------------
  logic [7:0]  ref_bytes [6];
  logic [47:0] p2;
  int          n;

  initial begin
    ref_bytes[0] = 8'h01; ref_bytes[1] = 8'h23; ref_bytes[2] = 8'hAB;
    ref_bytes[3] = 8'hCD; ref_bytes[4] = 8'hEF; ref_bytes[5] = 8'h47;
    @(negedge clk);
    apply_reset();

    // single packet, ready held high, with latency checks
    got_q.delete();
    tick(1'b1, 48'h0123_ABCDEF_47, 1'b1);
    chk("lat_count", bus.FIFO_COUNT, 3'd1);
    chk("lat_valid_n", bus.TX_VALID, 1'b0);
    tick(1'b0, '0, 1'b1);
    chk("lat_valid_n1", bus.TX_VALID, 1'b1);
    drain(40);
    chk("single_len", got_q.size(), NUM_BYTES);
    for (int k = 0; k < 6; k++)
      if (k < got_q.size()) chk("single_byte", got_q[k], ref_bytes[k]);

    // backpressure on byte index 2
    got_q.delete();
    tick(1'b1, 48'h0123_ABCDEF_47, 1'b1);
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1);
    repeat (5) begin
      tick(1'b0, '0, 1'b0);
      chk("stall_byte", bus.TX_BYTE, 8'hAB);
    end
    drain(40);
    chk("stall_len", got_q.size(), NUM_BYTES);

    // pointer wrap: six packets one at a time
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, rnd_pkt(), 1'b1);
      drain(40);
    end

    // full while IDLE, push on the pop edge
    apply_reset();
    for (int i = 0; i < 5; i++) tick(1'b1, rnd_pkt(), 1'b0);
    n = 0;
    while (m_send && n < 20) begin
      tick(1'b0, '0, 1'b1);
      n++;
    end
    chk("full_idle_timeout", n < 20, 1'b1);
    chk("full_idle_count", bus.FIFO_COUNT, 3'd4);
    tick(1'b1, rnd_pkt(), 1'b1);
    chk("full_pop_count", bus.FIFO_COUNT, 3'd4);
    chk("full_pop_ovf", bus.OVERFLOW, 1'b0);
    drain(80);

    // overflow with the downlink stalled
    for (int i = 0; i < 6; i++) tick(1'b1, rnd_pkt(), 1'b0);
    chk("ovf_count", bus.FIFO_COUNT, 3'd4);
    chk("ovf_flag", bus.OVERFLOW, 1'b1);
    drain(80);
    chk("ovf_sticky", bus.OVERFLOW, 1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 99) < 35, rnd_pkt(), $urandom_range(0, 99) < 70);
    drain(200);

    // reset after the third byte is accepted
    got_q.delete();
    tick(1'b1, rnd_pkt(), 1'b1);
    tick(1'b1, rnd_pkt(), 1'b1);
    n = 0;
    while (got_q.size() < 3 && n < 20) begin
      tick(1'b0, '0, 1'b1);
      n++;
    end
    chk("mid_timeout", n < 20, 1'b1);
    apply_reset();
    got_q.delete();
    p2 = rnd_pkt();
    tick(1'b1, p2, 1'b1);
    drain(40);
    chk("post_rst_len", got_q.size(), NUM_BYTES);
    if (got_q.size() > 0) chk("post_rst_first", got_q[0], p2[47:40]);

    chk("final_sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
